// File: rtl/stream_mux_arb_if.sv
// Handshake bundle for the arbitrated stream merge.
// master drives the producers and sink ready; slave is the merge block.
interface stream_mux_arb_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
);
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/stream_mux_arb.sv
// N-way registered stream merge with fixed-priority or
// round-robin arbitration and a one-word output register.
module stream_mux_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N),
  parameter int RR    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_arb_if.slave bus
);

  logic [WIDTH-1:0] ch [N];
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] idx;
  logic [SEL_W:0]   sum;
  logic             vld_q;
  logic             any;
  logic             load;
  logic             xfer;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  // Rotated search starting at ptr; ptr is pinned to 0 in fixed mode.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(N))
        sum = sum - (SEL_W+1)'(N);
      idx = sum[SEL_W-1:0];
      if (!any && bus.in_valid[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end

  assign load = ~vld_q | bus.out_ready;
  assign xfer = load & any;

  assign bus.in_ready =
    (rst_n & xfer) ? (N'(1) << gnt) : '0;

  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
      ptr    <= '0;
    end else if (load) begin
      vld_q <= any;
      if (any) begin
        data_q <= ch[gnt];
        sel_q  <= gnt;
        if (RR != 0)
          ptr <= (gnt == SEL_W'(N-1)) ? '0 : gnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed and randomized scoreboard bench for stream_mux_arb.
// Main instance is N=4 RR; side instances cover fixed priority and N=3.
module tb_stream_mux_arb;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_arb_if #(.WIDTH(W), .N(4)) bus_a ();
  stream_mux_arb_if #(.WIDTH(W), .N(4)) bus_b ();
  stream_mux_arb_if #(.WIDTH(W), .N(3)) bus_c ();

  stream_mux_arb #(.WIDTH(W), .N(4), .RR(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  stream_mux_arb #(.WIDTH(W), .N(4), .RR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );
  stream_mux_arb #(.WIDTH(W), .N(3), .RR(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c)
  );

  int checks = 0;
  int errors = 0;
  bit sb_on = 1'b0;
  logic [33:0] q [$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: the register word must equal the queue head.
  always @(negedge clk) begin
    if (sb_on) begin
      chk("sb_valid", bus_a.out_valid, q.size() != 0);
      if (bus_a.out_valid && q.size() != 0) begin
        chk("sb_data", bus_a.out_data, q[0][31:0]);
        chk("sb_sel", bus_a.out_sel, q[0][33:32]);
        if (bus_a.out_ready)
          void'(q.pop_front());
      end
    end
  end

  task automatic clear_inputs;
    bus_a.in_valid = '0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = '0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    bus_c.in_valid = '0; bus_c.in_data = '0; bus_c.out_ready = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  bit          v [4];
  logic [31:0] d [4];
  int          mptr;
  bit          mvalid;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    bus_a.in_valid = '1;
    bus_a.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus_a.out_valid, 0);
    chk("rst_data", bus_a.out_data, 0);
    chk("rst_sel", bus_a.out_sel, 0);
    chk("rst_ready", bus_a.in_ready, 0);
    bus_a.in_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", bus_a.out_valid, 0);

    // single channel
    @(posedge clk); #1;
    bus_a.in_data[2*W +: W] = 32'hDEADBEEF;
    bus_a.in_valid = 4'b0100;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", bus_a.in_ready, 4'b0100);
    @(posedge clk); #1;
    bus_a.in_valid = '0;
    chk("single_valid", bus_a.out_valid, 1);
    chk("single_data", bus_a.out_data, 32'hDEADBEEF);
    chk("single_sel", bus_a.out_sel, 2);

    // round-robin fairness
    do_reset();
    for (int i = 0; i < 4; i++)
      bus_a.in_data[i*W +: W] = 32'h100 + i;
    bus_a.in_valid = '1;
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("rr_sel", bus_a.out_sel, k % 4);
      chk("rr_data", bus_a.out_data, 32'h100 + k % 4);
    end

    // backpressure
    bus_a.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", bus_a.in_ready, 0);
      @(posedge clk); #1;
      chk("bp_valid", bus_a.out_valid, 1);
      chk("bp_sel", bus_a.out_sel, 3);
      chk("bp_data", bus_a.out_data, 32'h103);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_ready", bus_a.in_ready, 4'b0001);
    @(posedge clk); #1;
    chk("bp_resume_sel", bus_a.out_sel, 0);
    chk("bp_resume_data", bus_a.out_data, 32'h100);

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus_a.out_valid, 0);
    chk("mid_rst_data", bus_a.out_data, 0);
    chk("mid_rst_sel", bus_a.out_sel, 0);
    chk("mid_rst_ready", bus_a.in_ready, 0);
    bus_a.in_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_valid", bus_a.out_valid, 0);
    end
    @(posedge clk); #1;
    bus_a.in_valid = '1;
    @(posedge clk); #1;
    chk("restart_sel", bus_a.out_sel, 0);
    chk("restart_valid", bus_a.out_valid, 1);
    bus_a.in_valid = '0;

    // fixed priority
    for (int i = 0; i < 4; i++)
      bus_b.in_data[i*W +: W] = 32'h200 + i;
    bus_b.in_valid = 4'b1010;
    bus_b.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("fp_ready", bus_b.in_ready, 4'b0010);
      @(posedge clk); #1;
      chk("fp_sel", bus_b.out_sel, 1);
      chk("fp_data", bus_b.out_data, 32'h201);
    end
    bus_b.in_valid = '0;

    // non-power-of-two wrap
    for (int i = 0; i < 3; i++)
      bus_c.in_data[i*W +: W] = 32'h300 + i;
    bus_c.in_valid = 3'b100;
    bus_c.out_ready = 1'b1;
    @(negedge clk);
    chk("n3_ready", bus_c.in_ready, 3'b100);
    @(posedge clk); #1;
    chk("n3_first_sel", bus_c.out_sel, 2);
    bus_c.in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("n3_wrap_sel", bus_c.out_sel, k % 3);
      chk("n3_wrap_data", bus_c.out_data, 32'h300 + k % 3);
    end
    bus_c.in_valid = '0;

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0;
      d[i] = '0;
    end
    mptr = 0;
    mvalid = 1'b0;
    sb_on = 1'b1;
    for (int cyc = 0; cyc < 1530; cyc++) begin
      bit   ordy;
      bit   found;
      bit   ld;
      int   g;
      logic [3:0] er;
      @(posedge clk); #1;
      if (cyc < 1500) begin
        for (int i = 0; i < 4; i++)
          if (!v[i] && $urandom_range(2) == 0) begin
            v[i] = 1'b1;
            d[i] = $urandom;
          end
        ordy = ($urandom_range(3) != 0);
      end else begin
        ordy = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        bus_a.in_valid[i] = v[i];
        bus_a.in_data[i*W +: W] = d[i];
      end
      bus_a.out_ready = ordy;
      @(negedge clk); #1;
      ld = !mvalid || ordy;
      found = 1'b0;
      g = 0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (mptr + k) % 4;
        if (v[c]) begin
          found = 1'b1;
          g = c;
          break;
        end
      end
      er = (ld && found) ? 4'(1 << g) : 4'b0000;
      chk("rand_ready", bus_a.in_ready, er);
      if (ld && found) begin
        q.push_back({2'(g), d[g]});
        v[g] = 1'b0;
        mptr = (g + 1) % 4;
        mvalid = 1'b1;
      end else if (ld) begin
        mvalid = 1'b0;
      end
    end
    @(negedge clk); #1;
    sb_on = 1'b0;
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
